// File: rtl/fetch_exec_seq_pkg.sv
// Shared definitions for the fetch/execute sequencer and the instruction encoder tooling.
package fetch_exec_seq_pkg;

   // Opcode field values
   localparam logic [1:0] OP_LI   = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;
   localparam logic [1:0] OP_J    = 2'b11;

   // Instruction field positions: [7:6] opcode, [5:3] rd, [2:0] imm, [5:0] jump target
   localparam int unsigned OPC_HI = 7;
   localparam int unsigned OPC_LO = 6;
   localparam int unsigned RD_HI  = 5;
   localparam int unsigned RD_LO  = 3;
   localparam int unsigned IMM_HI = 2;
   localparam int unsigned IMM_LO = 0;
   localparam int unsigned JT_HI  = 5;
   localparam int unsigned JT_LO  = 0;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Sign-extend the 3-bit immediate to 8 bits
   function automatic logic [7:0] sext_imm(input logic [2:0] imm);
      return {{5{imm[2]}}, imm};
   endfunction

endpackage

// File: rtl/fetch_exec_seq_regfile.sv
// 8x8 register file: one write port, one operand read port, one debug read port.
module seq_regfile
   import fetch_exec_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [2:0] waddr,
   input  logic [7:0] wdata,
   input  logic [2:0] raddr,
   output logic [7:0] rdata,
   input  logic [2:0] dbg_sel,
   output logic [7:0] dbg_data
);

   logic [7:0] regs [8];

   // Register storage with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs <= '{default: '0};
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Combinational read ports
   always_comb begin
      rdata    = regs[raddr];
      dbg_data = regs[dbg_sel];
   end

endmodule

// File: rtl/fetch_exec_seq.sv
// Fetch/execute sequencer: fetches 8-bit instructions and executes li/addi/j/halt.
module fetch_exec_seq
   import fetch_exec_seq_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 8,
   parameter logic [7:0]  RESET_PC  = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] pc_out,
   input  logic [7:0] inst_code,
   output logic       busy,
   output logic       halted,
   output logic       retire,
   output logic [7:0] retire_pc,
   input  logic [2:0] dbg_sel,
   output logic [7:0] dbg_data
);

   state_t     state;
   logic [7:0] ir;
   logic [1:0] opcode;
   logic [2:0] rd;
   logic [2:0] imm;
   logic [7:0] rd_val;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic       fetch_oob;

   // Instruction decode and register write data
   always_comb begin
      opcode    = ir[OPC_HI:OPC_LO];
      rd        = ir[RD_HI:RD_LO];
      imm       = ir[IMM_HI:IMM_LO];
      rf_we     = (state == ST_EXEC) && ((opcode == OP_LI) || (opcode == OP_ADDI));
      rf_wdata  = (opcode == OP_LI) ? {5'b0, imm} : rd_val + sext_imm(imm);
      fetch_oob = (32'(pc_out) >= MEM_DEPTH);
   end

   seq_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (rf_we),
      .waddr    (rd),
      .wdata    (rf_wdata),
      .raddr    (rd),
      .rdata    (rd_val),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   // Sequencer FSM with registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         pc_out    <= RESET_PC;
         ir        <= '0;
         busy      <= 1'b0;
         halted    <= 1'b0;
         retire    <= 1'b0;
         retire_pc <= '0;
      end else begin
         retire <= 1'b0;
         unique case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state  <= ST_FETCH;
                  pc_out <= RESET_PC;
                  busy   <= 1'b1;
                  halted <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (fetch_oob) begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  ir    <= inst_code;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (opcode == OP_HALT) begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  state     <= ST_FETCH;
                  retire    <= 1'b1;
                  retire_pc <= pc_out;
                  if (opcode == OP_J) begin
                     pc_out <= {2'b00, ir[JT_HI:JT_LO]};
                  end else begin
                     pc_out <= pc_out + 8'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
